mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one sequential multiplier (MUL_top-style: start, 16-bit data_in, ldA/ldB load strobes,
//  done, product) between N_REQ requesters. Round-robin arbitration picks one request, holds
//  its operands, presents A then B on the shared data bus when the multiplier strobes ldA/ldB,
//  waits for done and returns the product with a one-cycle ack. A watchdog aborts hung jobs.
// PARAMETERS
//  N_REQ    4     number of requesters (2..8)
//  WIDTH    16    operand/product width, matches multiplier data bus
//  TIMEOUT  1024  max cycles in RUN before abort (>=4)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous reset, active low
//  req          in   N_REQ        req[i]=1: requester i wants a multiply; level, held until ack[i]
//  req_a        in   N_REQ*WIDTH  operand A of requester i at [i*WIDTH +: WIDTH]
//  req_b        in   N_REQ*WIDTH  operand B of requester i at [i*WIDTH +: WIDTH]
//  gnt          out  N_REQ        one-hot: requester owning the multiplier (RUN and RESP)
//  ack          out  N_REQ        one-cycle pulse: result/err valid for requester i
//  result       out  WIDTH        product of last completed job; held until next RESP
//  err          out  1            set with ack when job timed out; held with result
//  busy         out  1            1 in any state other than IDLE
//  mul_start    out  1            start to shared multiplier
//  mul_data     out  WIDTH        shared multiplier data_in
//  mul_ldA      in   1            multiplier loading A this cycle
//  mul_ldB      in   1            multiplier loading B this cycle
//  mul_done     in   1            multiplier done (level)
//  mul_product  in   WIDTH        multiplier product
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, rr pointer=0, gnt=0, ack=0, result=0, err=0, busy=0,
//    mul_start=0, watchdog=0. Outputs drop immediately, not at next edge. In-flight job lost, no ack.
//  - States: IDLE -> RUN -> RESP -> DRAIN -> IDLE.
//  - IDLE: if |req at edge k, winner = first i with req[i]=1 searching ptr, ptr+1, ... mod N_REQ.
//    At edge k latch winner index, req_a/req_b of winner into A_q/B_q; go RUN. No req: stay.
//  - RUN: mul_start=1 (from cycle k+1), gnt[winner]=1, watchdog counts up from 0 each cycle.
//    mul_done=1 -> latch result=mul_product, err=0; go RESP.
//    watchdog reaches TIMEOUT-1 with mul_done=0 -> result=0, err=1; go RESP.
//  - RESP (1 cycle): ack[winner]=1, gnt[winner]=1, mul_start=0; ptr=(winner+1) mod N_REQ.
//  - DRAIN: mul_start=0, gnt=0; stay while mul_done=1; mul_done=0 -> IDLE. Next grant earliest
//    one cycle after DRAIN exits, so multiplier always sees start low for >=2 cycles between jobs.
//  - mul_data combinational: ldA=1 -> A_q; else ldB=1 -> B_q; else 0. ldA wins if both high.
//    Strobes outside RUN ignored (mul_data=0).
//  - Arithmetic: no width change; result = mul_product as given (mod 2^WIDTH by multiplier).
//  - Requester contract: hold req and operands until ack. Operands are sampled only at grant edge;
//    later changes ignored. req dropped mid-job: job completes, ack still pulses.
//    req still high the cycle after ack: treated as new request, arbitrated with ptr advanced.
//  - Requests arriving during RUN/RESP/DRAIN wait; never lost while req stays high.
//  - Latency (ideal multiplier, done d cycles after start): req edge k -> ack at k+d+2.
// TESTING
//  1 Single: req[0], A=25, B=4 -> mul_data=25 on ldA, 4 on ldB; ack[0] one cycle, result=100, err=0.
//  2 Contention after reset: req[0],req[2] same cycle (A=3,B=5 / A=7,B=6) -> ack[0] result=15 first,
//    then ack[2] result=42; gnt never two-hot.
//  3 Fairness: all 4 req held high (re-asserted after each ack) -> grant order 0,1,2,3,0,1.
//  4 Timeout: TIMEOUT=8, stub multiplier never raises done -> ack pulses 8 cycles after start,
//    err=1, result=0, mul_start low in RESP; next req then served normally.
//  5 Reset mid-RUN: rst_n low while mul_start=1 -> mul_start, gnt, busy low immediately, no ack;
//    after release, held req[1] granted first (ptr=0, no req[0]).
//  6 Wrap: A=300, B=300 -> result=24464 (90000 mod 65536); DRAIN holds while done stays high.

Source files
------------

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin sharing of one sequential multiplier among N_REQ
//            requesters, with operand muxing, result return and a watchdog.
// Revision : 1.0
// ============================================================================
module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_data,
    input  logic                   mul_ldA,
    input  logic                   mul_ldB,
    input  logic                   mul_done,
    input  logic [WIDTH-1:0]       mul_product
);

    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_wd_w  = $clog2(TIMEOUT);

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(N_REQ - 1);
    localparam logic [c_idx_w:0]   c_n_req    = (c_idx_w + 1)'(N_REQ);
    localparam logic [c_wd_w-1:0]  c_wd_max   = c_wd_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_RESP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_winner;
    logic [c_idx_w-1:0]   w_win;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [c_wd_w-1:0]    r_wd;
    logic [WIDTH-1:0]     r_result;
    logic                 r_err;
    logic                 w_start;
    logic                 w_own;
    logic                 w_ack;
    logic [N_REQ-1:0]     w_onehot;

    // Round-robin search: walk offsets from farthest to nearest so the
    // nearest requester at or after the pointer is the last one written.
    always_comb begin
        logic [c_idx_w:0] sum;
        w_win = r_ptr;
        sum   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            sum = {1'b0, r_ptr} + (c_idx_w + 1)'(j);
            if (sum >= c_n_req) begin
                sum = sum - c_n_req;
            end
            if (req[sum[c_idx_w-1:0]]) begin
                w_win = sum[c_idx_w-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_own   = 1'b0;
        w_ack   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_start = 1'b1;
                w_own   = 1'b1;
                if (mul_done || (r_wd == c_wd_max)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_own  = 1'b1;
                w_ack  = 1'b1;
                w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!mul_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_winner <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_wd     <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_winner <= w_win;
                        r_a      <= req_a[w_win*WIDTH +: WIDTH];
                        r_b      <= req_b[w_win*WIDTH +: WIDTH];
                        r_wd     <= '0;
                    end
                end
                S_RUN: begin
                    if (mul_done) begin
                        r_result <= mul_product;
                        r_err    <= 1'b0;
                    end else if (r_wd == c_wd_max) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ptr <= (r_winner == c_last_idx) ? '0 : r_winner + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << r_winner;
    assign gnt       = w_own ? w_onehot : '0;
    assign ack       = w_ack ? w_onehot : '0;
    assign result    = r_result;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);
    assign mul_start = w_start;

    // Load strobes only steer the bus while a job owns the multiplier.
    assign mul_data = ((r_state == S_RUN) && mul_ldA) ? r_a :
                      ((r_state == S_RUN) && mul_ldB) ? r_b : '0;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mul_share_arbiter
// Brief    : Directed bench with stub multiplier and job-level reference model.
// Revision : 1.0
// ============================================================================
module tb_mul_share_arbiter;

    localparam int c_n  = 4;
    localparam int c_w  = 16;
    localparam int c_to = 8;

    localparam int J_FREE   = 0;
    localparam int J_ACTIVE = 1;
    localparam int J_REPORT = 2;
    localparam int J_SETTLE = 3;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [c_n-1:0]       req   = '0;
    logic [c_n*c_w-1:0]   req_a = '0;
    logic [c_n*c_w-1:0]   req_b = '0;
    logic [c_n-1:0]       gnt;
    logic [c_n-1:0]       ack;
    logic [c_w-1:0]       result;
    logic                 err;
    logic                 busy;
    logic                 mul_start;
    logic [c_w-1:0]       mul_data;
    logic                 mul_ldA;
    logic                 mul_ldB;
    logic                 mul_done;
    logic [c_w-1:0]       mul_product;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N_REQ(c_n), .WIDTH(c_w), .TIMEOUT(c_to)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .ack(ack), .result(result), .err(err), .busy(busy),
        .mul_start(mul_start), .mul_data(mul_data), .mul_ldA(mul_ldA),
        .mul_ldB(mul_ldB), .mul_done(mul_done), .mul_product(mul_product)
    );

    // Stub multiplier: ldA/ldB on 2nd/3rd start cycle, done after 5th.
    logic [7:0]     s_cnt  = '0;
    logic [c_w-1:0] s_a    = '0;
    logic [c_w-1:0] s_b    = '0;
    logic [c_w-1:0] s_prod = '0;
    logic           s_done = 1'b0;
    int             s_hold_left = 0;
    logic           hang     = 1'b0;
    int             hold_cfg = 0;
    logic           x_ldA    = 1'b0;

    assign mul_ldA     = (mul_start && s_cnt == 8'd1) || x_ldA;
    assign mul_ldB     = mul_start && s_cnt == 8'd2;
    assign mul_done    = s_done;
    assign mul_product = s_prod;

    always @(posedge clk) begin
        if (mul_start) begin
            s_cnt <= s_cnt + 8'd1;
            if (s_cnt == 8'd1) s_a <= mul_data;
            if (s_cnt == 8'd2) s_b <= mul_data;
            if (s_cnt == 8'd4 && !hang) begin
                s_done      <= 1'b1;
                s_prod      <= s_a * s_b;
                s_hold_left <= hold_cfg;
            end
        end else begin
            s_cnt <= '0;
            if (s_done) begin
                if (s_hold_left > 0) s_hold_left <= s_hold_left - 1;
                else                 s_done      <= 1'b0;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int         who;
        logic [15:0] res;
        logic       e;
    } ack_t;
    ack_t ack_log[$];

    logic [c_n-1:0] ack_q = '0;
    int pending[c_n] = '{default: 0};

    // Reference model: one job at a time through grant, run, report, settle.
    int             m_stage = J_FREE;
    int             m_ptr   = 0;
    int             m_owner = 0;
    int             m_age   = 0;
    logic [c_w-1:0] m_a     = '0;
    logic [c_w-1:0] m_b     = '0;
    logic [c_w-1:0] m_res   = '0;
    logic           m_err   = 1'b0;

    initial forever begin
        logic [c_n-1:0] e_gnt;
        logic [c_w-1:0] e_data;
        bit             found;
        int             who;
        @(negedge clk);
        ack_q = ack;
        if (!rst_n) begin
            m_stage = J_FREE; m_ptr = 0; m_res = '0; m_err = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_gnt", gnt, 0);
            check("rst_ack", ack, 0);
            check("rst_start", mul_start, 0);
            check("rst_result", result, 0);
            check("rst_err", err, 0);
        end else begin
            e_gnt  = (m_stage == J_ACTIVE || m_stage == J_REPORT) ? c_n'(1 << m_owner) : '0;
            e_data = (m_stage == J_ACTIVE && mul_ldA) ? m_a :
                     (m_stage == J_ACTIVE && mul_ldB) ? m_b : '0;
            check("gnt_onehot", ($countones(gnt) <= 1), 1);
            check("gnt", gnt, e_gnt);
            check("ack", ack, (m_stage == J_REPORT) ? e_gnt : '0);
            check("busy", busy, (m_stage != J_FREE));
            check("mul_start", mul_start, (m_stage == J_ACTIVE));
            check("mul_data", mul_data, e_data);
            check("result", result, m_res);
            check("err", err, m_err);
            if (ack != '0) begin
                who = -1;
                for (int i = 0; i < c_n; i++) if (ack[i]) who = i;
                ack_log.push_back('{who, result, err});
            end
            case (m_stage)
                J_FREE: begin
                    found = 1'b0;
                    for (int j = 0; j < c_n; j++) begin
                        if (!found && req[(m_ptr + j) % c_n]) begin
                            found   = 1'b1;
                            m_owner = (m_ptr + j) % c_n;
                        end
                    end
                    if (found) begin
                        m_a     = req_a[m_owner*c_w +: c_w];
                        m_b     = req_b[m_owner*c_w +: c_w];
                        m_age   = 0;
                        m_stage = J_ACTIVE;
                    end
                end
                J_ACTIVE: begin
                    if (mul_done) begin
                        m_res = mul_product; m_err = 1'b0; m_stage = J_REPORT;
                    end else if (m_age == c_to - 1) begin
                        m_res = '0; m_err = 1'b1; m_stage = J_REPORT;
                    end else begin
                        m_age = m_age + 1;
                    end
                end
                J_REPORT: begin
                    m_ptr   = (m_owner + 1) % c_n;
                    m_stage = J_SETTLE;
                end
                default: if (!mul_done) m_stage = J_FREE;
            endcase
        end
    end

    // Requesters keep req high until their last pending job is acked.
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < c_n; i++) begin
            if (ack_q[i] && pending[i] > 0) begin
                pending[i] = pending[i] - 1;
                if (pending[i] == 0) req[i] = 1'b0;
            end
        end
    end

    task automatic post(input int i, input int a, input int b, input int n);
        req_a[i*c_w +: c_w] = c_w'(a);
        req_b[i*c_w +: c_w] = c_w'(b);
        pending[i] = n;
        req[i]     = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (ack_log.size() < n && c < budget) begin
            @(negedge clk); #1; c++;
        end
        check("wait_ack", (ack_log.size() >= n), 1);
    endtask

    task automatic expect_ack(input string name, input int k, input int who, input longint res, input longint e);
        if (ack_log.size() > k) begin
            check({name, "_who"}, ack_log[k].who, who);
            check({name, "_res"}, ack_log[k].res, res);
            check({name, "_err"}, ack_log[k].e, e);
        end else begin
            check({name, "_missing"}, ack_log.size(), k + 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < c_n; i++) pending[i] = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ack_log.delete();
    endtask

    initial begin
        int n;
        int c;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk); #1;
        check("init_busy", busy, 0);
        check("init_result", result, 0);

        // Stray strobe while idle must not drive the bus
        @(posedge clk); #2 x_ldA = 1'b1;
        #1 check("stray_ldA", mul_data, 0);
        @(posedge clk); #2 x_ldA = 1'b0;

        // 1: single job
        post(0, 25, 4, 1);
        wait_log(1, 60);
        expect_ack("t1", 0, 0, 100, 0);
        check("t1_busA", s_a, 25);
        check("t1_busB", s_b, 4);

        // 2: contention right after reset
        do_reset();
        post(0, 3, 5, 1);
        post(2, 7, 6, 1);
        wait_log(2, 80);
        expect_ack("t2a", 0, 0, 15, 0);
        expect_ack("t2b", 1, 2, 42, 0);

        // 3: fairness with re-asserted requests
        do_reset();
        post(0, 1, 2, 2);
        post(1, 2, 3, 2);
        post(2, 3, 4, 1);
        post(3, 4, 5, 1);
        wait_log(6, 200);
        expect_ack("t3_0", 0, 0, 2, 0);
        expect_ack("t3_1", 1, 1, 6, 0);
        expect_ack("t3_2", 2, 2, 12, 0);
        expect_ack("t3_3", 3, 3, 20, 0);
        expect_ack("t3_4", 4, 0, 2, 0);
        expect_ack("t3_5", 5, 1, 6, 0);

        // 4: watchdog abort, then a normal job
        repeat (4) @(posedge clk);
        ack_log.delete();
        hang = 1'b1;
        #2 post(1, 11, 13, 1);
        c = 0;
        while (!mul_start && c < 40) begin @(negedge clk); #1; c++; end
        check("t4_started", mul_start, 1);
        n = 0;
        while (ack == '0 && n < 40) begin @(negedge clk); #1; n++; end
        check("t4_latency", n, 8);
        check("t4_start_resp", mul_start, 0);
        wait_log(1, 10);
        expect_ack("t4", 0, 1, 0, 1);
        hang = 1'b0;
        post(2, 9, 9, 1);
        wait_log(2, 60);
        expect_ack("t4n", 1, 2, 81, 0);

        // 5: reset in the middle of a job
        repeat (4) @(posedge clk);
        ack_log.delete();
        #2 post(3, 2, 2, 1);
        c = 0;
        while (!mul_start && c < 40) begin @(negedge clk); #1; c++; end
        @(posedge clk); #3;
        post(1, 5, 5, 1);
        rst_n = 1'b0;
        #1;
        check("t5_start_drop", mul_start, 0);
        check("t5_gnt_drop", gnt, 0);
        check("t5_busy_drop", busy, 0);
        check("t5_ack_drop", ack, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check("t5_no_ack", ack_log.size(), 0);
        wait_log(2, 80);
        expect_ack("t5a", 0, 1, 25, 0);
        expect_ack("t5b", 1, 3, 4, 0);

        // 6: product wrap and drain held by a lingering done
        repeat (4) @(posedge clk);
        ack_log.delete();
        hold_cfg = 3;
        #2 post(0, 300, 300, 1);
        wait_log(1, 60);
        expect_ack("t6", 0, 0, 24464, 0);
        n = 0;
        while (busy && n < 20) begin @(negedge clk); #1; if (busy) n++; end
        check("t6_drain_cycles", n, 4);
        hold_cfg = 0;

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench did not complete");
    end

endmodule
`default_nettype wire
